instr_fetch_loader: RTL and testbench



---
 rtl/instr_fetch_loader.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_loader.sv
`default_nettype none
// instr_fetch_loader: instruction memory filled over a byte-serial load port, then read by a PC.
// Rev 1.0 - initial release
module instr_fetch_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W:0]   load_words,
  output logic              halted,
  output logic              fetch_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_pc, w_pc_nxt;
  logic              r_fetch_err, w_fetch_err_nxt;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_asm;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W:0]   r_load_words;
  logic [31:0]       r_mem [DEPTH];

  logic              w_accept;
  logic              w_word_done;
  logic              w_load_done;
  logic [31:0]       w_word;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_in_range;

  assign w_accept    = (r_state == S_LOAD) && ld_valid;
  // Lanes above the current byte are still zero in r_asm, so a partial word flushes zero-filled.
  assign w_word      = r_asm | ({24'd0, ld_data} << {r_byte_cnt, 3'b000});
  assign w_word_done = w_accept && (ld_last || (r_byte_cnt == 2'd3));
  assign w_load_done = w_accept && (ld_last || ((r_byte_cnt == 2'd3) && (&r_wr_addr)));
  assign w_rd_idx    = r_pc[ADDR_W+1:2];
  assign w_in_range  = (r_pc[31:ADDR_W+2] == '0) && ({1'b0, w_rd_idx} < r_load_words);

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_fetch_err_nxt = r_fetch_err;
    ld_ready        = 1'b0;
    instr_valid     = 1'b0;
    instr           = NOP_WORD;
    unique case (r_state)
      S_LOAD: begin
        ld_ready = 1'b1;
        if (w_load_done) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = RESET_PC;
        end
      end
      S_RUN: begin
        if (!w_in_range) begin
          w_state_nxt = S_HALT;
        end else begin
          instr_valid = 1'b1;
          instr       = r_mem[w_rd_idx];
          if (!stall) begin
            if (branch_taken) begin
              if (branch_target[1:0] != 2'b00) begin
                w_fetch_err_nxt = 1'b1;
                w_state_nxt     = S_HALT;
              end else begin
                w_pc_nxt = branch_target;
              end
            end else begin
              w_pc_nxt = r_pc + 32'd4;
            end
          end
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LOAD;
      r_pc         <= RESET_PC;
      r_fetch_err  <= 1'b0;
      r_byte_cnt   <= 2'd0;
      r_asm        <= 32'd0;
      r_wr_addr    <= '0;
      r_load_words <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_fetch_err <= w_fetch_err_nxt;
      if (w_accept) begin
        if (w_word_done) begin
          r_byte_cnt   <= 2'd0;
          r_asm        <= 32'd0;
          r_wr_addr    <= r_wr_addr + 1'b1;
          r_load_words <= r_load_words + 1'b1;
        end else begin
          r_byte_cnt <= r_byte_cnt + 2'd1;
          r_asm      <= w_word;
        end
      end
    end
  end

  // Memory is never cleared; words beyond load_words are unreachable.
  always_ff @(posedge clk) begin
    if (w_word_done) begin
      r_mem[r_wr_addr] <= w_word;
    end
  end

  assign pc         = r_pc;
  assign load_words = r_load_words;
  assign halted     = (r_state == S_HALT);
  assign fetch_err  = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_loader.sv
`default_nettype none
// tb_instr_fetch_loader: directed and randomized checks of instr_fetch_loader against a byte-queue model.
// Rev 1.0 - initial release
module tb_instr_fetch_loader;

  localparam int          AW    = 2;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'd0;
  logic        ld_last = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        ld_ready;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [AW:0] load_words;
  logic        halted;
  logic        fetch_err;

  instr_fetch_loader #(
    .ADDR_W  (AW),
    .RESET_PC(32'h0000_0000),
    .NOP_WORD(NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .load_words   (load_words),
    .halted       (halted),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0=loading, 1=running, 2=halted.
  int          m_state;
  logic [31:0] m_pc;
  bit          m_ferr;
  int          m_lw;
  logic [7:0]  m_q[$];
  logic [31:0] m_mem [DEPTH];
  logic [7:0]  prog[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_inrange();
    return (m_pc % 4 == 0) && (longint'(m_pc) / 4 < longint'(m_lw));
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pc    = 32'd0;
    m_ferr  = 1'b0;
    m_lw    = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit st, input bit br, input logic [31:0] tgt,
                            input bit lv, input logic [7:0] ld, input bit ll, output bit acc);
    acc = 1'b0;
    case (m_state)
      0: if (lv) begin
        acc = 1'b1;
        m_q.push_back(ld);
        if (ll || m_q.size() == 4 * DEPTH) begin
          m_lw = (m_q.size() + 3) / 4;
          for (int w = 0; w < m_lw; w++) begin
            m_mem[w] = 32'd0;
            for (int b = 0; b < 4; b++)
              if (4 * w + b < m_q.size()) m_mem[w][8*b +: 8] = m_q[4*w+b];
          end
          m_state = 1;
          m_pc    = 32'd0;
        end else begin
          m_lw = m_q.size() / 4;
        end
      end
      1: begin
        if (!m_inrange()) m_state = 2;
        else if (st) m_pc = m_pc;
        else if (br) begin
          if (tgt % 4 != 0) begin
            m_ferr  = 1'b1;
            m_state = 2;
          end else begin
            m_pc = tgt;
          end
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
      default: m_state = 2;
    endcase
  endtask

  task automatic cmp_outputs();
    bit v;
    v = (m_state == 1) && m_inrange();
    check_eq("pc", pc, m_pc);
    check_eq("instr_valid", 32'(instr_valid), 32'(v));
    check_eq("instr", instr, v ? m_mem[int'(m_pc >> 2)] : NOP);
    check_eq("ld_ready", 32'(ld_ready), 32'(m_state == 0));
    check_eq("load_words", 32'(load_words), 32'(m_lw));
    check_eq("halted", 32'(halted), 32'(m_state == 2));
    check_eq("fetch_err", 32'(fetch_err), 32'(m_ferr));
  endtask

  // Called at a negedge: drive, clock, advance model, compare at the next negedge.
  task automatic cycle(input bit st, input bit br, input logic [31:0] tgt,
                       input bit lv, input logic [7:0] ld, input bit ll, output bit acc);
    stall = st; branch_taken = br; branch_target = tgt;
    ld_valid = lv; ld_data = ld; ld_last = ll;
    @(posedge clk);
    model_step(st, br, tgt, lv, ld, ll, acc);
    @(negedge clk);
    cmp_outputs();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0, acc);
  endtask

  task automatic load_prog(input bit use_last, input bit gaps, input int max_cycles);
    int idx = 0;
    bit acc, lv, ll;
    for (int c = 0; c < max_cycles && idx < prog.size(); c++) begin
      lv = gaps ? ($urandom % 4 != 0) : 1'b1;
      ll = use_last && (idx == prog.size() - 1);
      cycle(1'b0, 1'b0, 32'd0, lv, prog[idx], ll, acc);
      if (acc) idx++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic async_reset();
    stall = 1'b0; branch_taken = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    #3 rst_n = 1'b0;
    #1 model_reset();
    cmp_outputs();
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    bit st, br, lv;
    logic [31:0] tgt;
    int n;

    model_reset();
    @(negedge clk);
    cmp_outputs();
    rst_n = 1'b1;

    // Three-instruction program, run off the end.
    prog = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'h33, 8'h86, 8'hb5, 8'h00};
    load_prog(1'b1, 1'b0, prog.size());
    check_eq("t1_lw", 32'(load_words), 32'd3);
    check_eq("t1_i0", instr, 32'h0010_0513);
    idle(1);
    check_eq("t1_i1", instr, 32'h0020_0593);
    idle(1);
    check_eq("t1_i2", instr, 32'h00b5_8633);
    idle(1);
    check_eq("t1_pc12_valid", 32'(instr_valid), 32'd0);
    idle(1);
    check_eq("t1_halted", 32'(halted), 32'd1);

    // Partial final word is zero-filled.
    async_reset();
    prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    load_prog(1'b1, 1'b0, prog.size());
    check_eq("t2_lw", 32'(load_words), 32'd2);
    check_eq("t2_w0", instr, 32'hDDCC_BBAA);
    idle(1);
    check_eq("t2_w1", instr, 32'h0000_2211);

    // Branch, stall priority, misaligned branch.
    async_reset();
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back(8'($urandom));
    load_prog(1'b1, 1'b0, prog.size());
    idle(2);
    check_eq("t3_pc8", pc, 32'd8);
    cycle(1'b0, 1'b1, 32'd0, 1'b0, 8'd0, 1'b0, acc);
    check_eq("t3_br0", pc, 32'd0);
    idle(2);
    cycle(1'b1, 1'b1, 32'd0, 1'b0, 8'd0, 1'b0, acc);
    check_eq("t3_stall", pc, 32'd8);
    idle(1);
    check_eq("t3_pc12", pc, 32'd12);
    cycle(1'b0, 1'b1, 32'd6, 1'b0, 8'd0, 1'b0, acc);
    check_eq("t3_ferr", 32'(fetch_err), 32'd1);
    check_eq("t3_halt", 32'(halted), 32'd1);
    check_eq("t3_pchold", pc, 32'd12);
    for (int i = 0; i < 4; i++) cycle(1'($urandom), 1'b1, 32'd0, 1'b1, 8'hFF, 1'b1, acc);
    check_eq("t3_nop", instr, NOP);
    async_reset();
    check_eq("t3_rst_ready", 32'(ld_ready), 32'd1);

    // Fill the memory without ld_last; the 17th byte is refused.
    prog.delete();
    for (int i = 0; i < 17; i++) prog.push_back(8'($urandom));
    load_prog(1'b0, 1'b0, 16);
    check_eq("t4_lw", 32'(load_words), 32'd4);
    check_eq("t4_ready", 32'(ld_ready), 32'd0);
    check_eq("t4_pc0", pc, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, prog[16], 1'b1, acc);

    // Reset mid-load, then reload a single word.
    async_reset();
    prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    load_prog(1'b0, 1'b0, 5);
    async_reset();
    check_eq("t5_lw_clr", 32'(load_words), 32'd0);
    prog = '{8'h37, 8'h12, 8'hAB, 8'h5E};
    load_prog(1'b1, 1'b0, prog.size());
    check_eq("t5_lw", 32'(load_words), 32'd1);
    check_eq("t5_w0", instr, 32'h5EAB_1237);

    // Randomized programs and control.
    for (int it = 0; it < 40; it++) begin
      async_reset();
      n = $urandom_range(1, 20);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
      load_prog(n <= 16, 1'b1, 200);
      for (int c = 0; c < 15; c++) begin
        st = ($urandom % 4 == 0);
        br = ($urandom % 3 == 0);
        lv = 1'($urandom);
        case ($urandom % 8)
          0:       tgt = $urandom & 32'hFFFF_FFFC;
          1:       tgt = ($urandom_range(0, 4 * DEPTH) & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
          default: tgt = 32'($urandom_range(0, DEPTH + 1)) * 32'd4;
        endcase
        cycle(st, br, tgt, lv, 8'($urandom), 1'($urandom), acc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
